// File: rtl/my_reg_file16.sv
// my_reg_file16: R0-R14 clocked storage with two combinational read ports; reads of R15 return PC+8.
// Writes are strobed by a one-hot select, and a malformed select raises a sticky error flag.
module my_reg_file16 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [15:0]       wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        ra1,
    input  logic [3:0]        ra2,
    input  logic [DATA_W-1:0] r15_in,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              onehot_err,
    output logic              wr_busy
);
    localparam int NREGS = 15;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              err_q;
    logic              err_d;
    logic              busy_q;
    logic              busy_d;

    logic              wsel_legal;
    logic              wr_accept;
    logic              wr_malformed;

    // Exactly one bit set; unknown bits make the result non-true, so they fall on the malformed side.
    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction

    assign wsel_legal   = is_onehot(wsel);
    assign wr_accept    = we && wsel_legal;
    assign wr_malformed = we && !wsel_legal;

    // A one-hot R15 strobe is accepted but has no storage bit to land in.
    always_comb begin
        regs_d = regs_q;
        if (wr_accept) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    always_comb begin
        err_d  = err_q | wr_malformed;
        busy_d = wr_accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    // Read path has no bypass: a same-cycle write is seen only after the edge.
    always_comb begin
        rd1 = r15_in;
        if (ra1 != 4'hF) begin
            rd1 = regs_q[ra1];
        end
    end

    always_comb begin
        rd2 = r15_in;
        if (ra2 != 4'hF) begin
            rd2 = regs_q[ra2];
        end
    end

    assign onehot_err = err_q;
    assign wr_busy    = busy_q;

endmodule

// File: tb/tb_my_reg_file16.sv
// Table-driven bench for my_reg_file16: each record is one clock cycle of inputs plus the
// outputs expected just before that cycle's rising edge, routed through a scoreboard queue.
module tb_my_reg_file16;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [15:0]       wsel;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        ra1;
    logic [3:0]        ra2;
    logic [DATA_W-1:0] r15_in;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              onehot_err;
    logic              wr_busy;

    my_reg_file16 #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .wsel       (wsel),
        .wdata      (wdata),
        .ra1        (ra1),
        .ra2        (ra2),
        .r15_in     (r15_in),
        .rd1        (rd1),
        .rd2        (rd2),
        .onehot_err (onehot_err),
        .wr_busy    (wr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst_n;
        logic              we;
        logic [15:0]       wsel;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        ra1;
        logic [3:0]        ra2;
        logic [DATA_W-1:0] r15;
        logic              chk;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic              eerr;
        logic              ebusy;
        string             tag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    int n_checks = 0;
    int n_errs   = 0;

    localparam logic [DATA_W-1:0] PC8 = 32'h0000_1008;

    task automatic add(input logic r, input logic w, input logic [15:0] s, input logic [DATA_W-1:0] d,
                       input logic [3:0] a1, input logic [3:0] a2, input logic [DATA_W-1:0] p,
                       input logic c, input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] x2,
                       input logic xe, input logic xb, input string t);
        vec_t v;
        v.rst_n = r;  v.we = w;   v.wsel = s;  v.wdata = d;
        v.ra1 = a1;   v.ra2 = a2; v.r15 = p;   v.chk = c;
        v.e1 = x1;    v.e2 = x2;  v.eerr = xe; v.ebusy = xb;
        v.tag = t;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] sweep_val(input int i);
        return 32'h1000_0000 + DATA_W'(i);
    endfunction

    // Register contents after the malformed-strobe section (R2 rewritten there).
    function automatic logic [DATA_W-1:0] pre_reset_val(input int i);
        return (i == 2) ? 32'hCAFE_0002 : sweep_val(i);
    endfunction

    initial begin
        logic [15:0] m;
        vec_t        v;
        vec_t        e;

        rst_n = 1'b0; we = 1'b0; wsel = '0; wdata = '0;
        ra1 = '0; ra2 = '0; r15_in = PC8;

        // Reset held for two edges, then a read sweep of every address.
        add(0, 0, 16'h0000, '0, 0, 1, PC8, 0, '0, '0, 0, 0, "rst0");
        add(0, 0, 16'h0000, '0, 0, 1, PC8, 1, '0, '0, 0, 0, "rst1");
        for (int i = 0; i < 15; i++)
            add(1, 0, 16'h0000, '0, 4'(i), 4'(14 - i), PC8, 1, '0, '0, 0, 0, "rst_read");
        add(1, 0, 16'h0000, '0, 15, 15, PC8, 1, PC8, PC8, 0, 0, "rst_r15");

        // Single write to R5: old value before the edge, new value after, one-cycle busy.
        add(1, 1, 16'h0020, 32'hDEAD_BEEF, 5, 5, PC8, 1, '0, '0, 0, 0, "wr5_same");
        add(1, 0, 16'h0000, '0, 5, 5, PC8, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, "wr5_after");
        add(1, 0, 16'h0000, '0, 5, 5, PC8, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, "wr5_idle");

        // Back-to-back sweep of R0..R14.
        for (int i = 0; i < 15; i++) begin
            m = 16'h0001 << i;
            add(1, 1, m, sweep_val(i), 4'(i), 4'(i), PC8, 1,
                (i == 5) ? 32'hDEAD_BEEF : '0, (i == 5) ? 32'hDEAD_BEEF : '0, 0, (i != 0), "sweep_wr");
        end
        add(1, 0, 16'h0000, '0, 0, 1, PC8, 1, sweep_val(0), sweep_val(1), 0, 1, "sweep_tail");
        for (int i = 0; i < 15; i++)
            add(1, 0, 16'h0000, '0, 4'(i), 4'(i), PC8, 1, sweep_val(i), sweep_val(i), 0, 0, "sweep_rd");

        // R15 write: accepted, no storage change, no error.
        add(1, 1, 16'h8000, 32'hFFFF_FFFF, 15, 3, 32'h0000_0040, 1, 32'h0000_0040, sweep_val(3), 0, 0, "r15_wr");
        add(1, 0, 16'h0000, '0, 15, 14, 32'h0000_0040, 1, 32'h0000_0040, sweep_val(14), 0, 1, "r15_after");
        for (int i = 0; i < 15; i++)
            add(1, 0, 16'h0000, '0, 4'(i), 4'(14 - i), PC8, 1, sweep_val(i), sweep_val(14 - i), 0, 0, "r15_keep");

        // Malformed strobes: two bits set, then sticky across a valid write, then zero strobe.
        add(1, 1, 16'h0003, 32'h5555_5555, 0, 1, PC8, 1, sweep_val(0), sweep_val(1), 0, 0, "bad2_wr");
        add(1, 0, 16'h0000, '0, 0, 1, PC8, 1, sweep_val(0), sweep_val(1), 1, 0, "bad2_after");
        add(1, 1, 16'h0004, 32'hCAFE_0002, 2, 2, PC8, 1, sweep_val(2), sweep_val(2), 1, 0, "sticky_wr");
        add(1, 0, 16'h0000, '0, 2, 2, PC8, 1, 32'hCAFE_0002, 32'hCAFE_0002, 1, 1, "sticky_after");
        add(1, 1, 16'h0000, 32'h5555_5555, 0, 1, PC8, 1, sweep_val(0), sweep_val(1), 1, 0, "bad0_wr");
        add(1, 0, 16'h0000, '0, 0, 1, PC8, 1, sweep_val(0), sweep_val(1), 1, 0, "bad0_after");

        // Reset asserted on the same edge as the R7 write of a new sweep.
        for (int i = 0; i < 8; i++) begin
            m = 16'h0001 << i;
            add((i != 7), 1, m, 32'hAAAA_0000 + DATA_W'(i), 4'(i), 4'(i), PC8, 1,
                pre_reset_val(i), pre_reset_val(i), 1, (i != 0), "midrst_wr");
        end
        add(1, 0, 16'h0000, '0, 7, 0, PC8, 1, '0, '0, 0, 0, "midrst_after");
        for (int i = 0; i < 15; i++)
            add(1, 0, 16'h0000, '0, 4'(i), 4'(14 - i), PC8, 1, '0, '0, 0, 0, "midrst_rd");
        add(1, 1, 16'h0080, 32'h1234_5678, 7, 7, PC8, 1, '0, '0, 0, 0, "post_wr");
        add(1, 0, 16'h0000, '0, 7, 6, PC8, 1, 32'h1234_5678, '0, 0, 1, "post_after");

        // Illegal pattern with we=0 is ignored entirely.
        add(1, 0, 16'h00FF, 32'hFFFF_FFFF, 0, 7, PC8, 1, '0, 32'h1234_5678, 0, 0, "we0_ff");
        add(1, 0, 16'h0000, '0, 0, 1, PC8, 1, '0, '0, 0, 0, "we0_after");

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            v = tbl[k];
            rst_n  = v.rst_n;
            we     = v.we;
            wsel   = v.wsel;
            wdata  = v.wdata;
            ra1    = v.ra1;
            ra2    = v.ra2;
            r15_in = v.r15;
            sb.push_back(v);
            #1;
            e = sb.pop_front();
            if (e.chk) begin
                check($sformatf("%s[%0d].rd1", e.tag, k), rd1, e.e1);
                check($sformatf("%s[%0d].rd2", e.tag, k), rd2, e.e2);
                check($sformatf("%s[%0d].onehot_err", e.tag, k), DATA_W'(onehot_err), DATA_W'(e.eerr));
                check($sformatf("%s[%0d].wr_busy", e.tag, k), DATA_W'(wr_busy), DATA_W'(e.ebusy));
            end
        end
        @(negedge clk);
        we = 1'b0;
        check("scoreboard_drained", DATA_W'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
